// File: rtl/glb_tile_pcfg_dma.sv
// Parallel-config DMA initiator: streams addr/data entries out of the GLB bank
// and turns each one into a CGRA config write packet on the c2sw channel.
module glb_tile_pcfg_dma #(
  parameter int GLB_ADDR_WIDTH      = 22,
  parameter int BANK_DATA_WIDTH     = 64,
  parameter int CGRA_CFG_ADDR_WIDTH = 32,
  parameter int CGRA_CFG_DATA_WIDTH = 32,
  parameter int MAX_NUM_CFG_WIDTH   = 16,
  parameter int RD_LATENCY          = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_pc_dma_mode,
  input  logic [GLB_ADDR_WIDTH-1:0]      cfg_pc_dma_header_start_addr,
  input  logic [MAX_NUM_CFG_WIDTH-1:0]   cfg_pc_dma_header_num_cfg,
  input  logic                           pc_start_pulse,
  output logic                           pc_done_pulse,
  output logic                           pc_busy,
  output logic                           rdrq_rd_en,
  output logic [GLB_ADDR_WIDTH-1:0]      rdrq_rd_addr,
  input  logic                           rdrs_rd_data_valid,
  input  logic [BANK_DATA_WIDTH-1:0]     rdrs_rd_data,
  output logic                           cgra_cfg_c2sw_rd_en,
  output logic                           cgra_cfg_c2sw_wr_en,
  output logic [CGRA_CFG_ADDR_WIDTH-1:0] cgra_cfg_c2sw_addr,
  output logic [CGRA_CFG_DATA_WIDTH-1:0] cgra_cfg_c2sw_data
);

  localparam int CNT_W = MAX_NUM_CFG_WIDTH + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  if (RD_LATENCY < 1) begin : g_bad_rd_latency
    $error("glb_tile_pcfg_dma: RD_LATENCY must be at least 1");
  end

  logic [1:0]       state;
  logic [CNT_W-1:0] num_cfg_q;
  logic [CNT_W-1:0] req_cnt;
  logic [CNT_W-1:0] rsp_cnt;
  logic             start_fire;
  logic             rsp_accept;

  // Counters carry one extra bit so a full-range entry count never wraps.
  assign start_fire = (state == IDLE) && pc_start_pulse && cfg_pc_dma_mode;
  assign rsp_accept = rdrs_rd_data_valid && ((state == REQ) || (state == DRAIN))
                      && (rsp_cnt < num_cfg_q);

  assign pc_busy             = (state != IDLE);
  assign cgra_cfg_c2sw_rd_en = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      num_cfg_q     <= '0;
      req_cnt       <= '0;
      rdrq_rd_en    <= 1'b0;
      rdrq_rd_addr  <= '0;
      pc_done_pulse <= 1'b0;
    end else begin
      pc_done_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start_fire) begin
            num_cfg_q <= CNT_W'(cfg_pc_dma_header_num_cfg);
            if (cfg_pc_dma_header_num_cfg != '0) begin
              state        <= REQ;
              req_cnt      <= CNT_W'(1);
              rdrq_rd_en   <= 1'b1;
              rdrq_rd_addr <= {cfg_pc_dma_header_start_addr[GLB_ADDR_WIDTH-1:3], 3'b000};
            end else begin
              state         <= DONE;
              req_cnt       <= '0;
              pc_done_pulse <= 1'b1;
            end
          end
        end
        REQ: begin
          // req_cnt counts requests already on the port, so the last one
          // leaves REQ at the edge after it was presented.
          if (req_cnt < num_cfg_q) begin
            rdrq_rd_addr <= rdrq_rd_addr + GLB_ADDR_WIDTH'(8);
            req_cnt      <= req_cnt + CNT_W'(1);
          end else begin
            rdrq_rd_en <= 1'b0;
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          if (rsp_cnt == num_cfg_q) begin
            state         <= DONE;
            pc_done_pulse <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_cnt             <= '0;
      cgra_cfg_c2sw_wr_en <= 1'b0;
      cgra_cfg_c2sw_addr  <= '0;
      cgra_cfg_c2sw_data  <= '0;
    end else begin
      cgra_cfg_c2sw_wr_en <= rsp_accept;
      if (start_fire) begin
        rsp_cnt <= '0;
      end else if (rsp_accept) begin
        rsp_cnt            <= rsp_cnt + CNT_W'(1);
        cgra_cfg_c2sw_addr <= rdrs_rd_data[CGRA_CFG_ADDR_WIDTH+CGRA_CFG_DATA_WIDTH-1:CGRA_CFG_DATA_WIDTH];
        cgra_cfg_c2sw_data <= rdrs_rd_data[CGRA_CFG_DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_glb_tile_pcfg_dma.sv
// Scoreboard bench for glb_tile_pcfg_dma: a fixed-latency bank model answers
// reads, and a cycle-level reference model predicts every output event.
module tb_glb_tile_pcfg_dma;

  localparam int AW  = 22;
  localparam int DW  = 64;
  localparam int CAW = 32;
  localparam int CDW = 32;
  localparam int NW  = 16;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           cfg_pc_dma_mode = 1'b0;
  logic [AW-1:0]  cfg_pc_dma_header_start_addr = '0;
  logic [NW-1:0]  cfg_pc_dma_header_num_cfg = '0;
  logic           pc_start_pulse = 1'b0;
  logic           pc_done_pulse;
  logic           pc_busy;
  logic           rdrq_rd_en;
  logic [AW-1:0]  rdrq_rd_addr;
  logic           rdrs_rd_data_valid;
  logic [DW-1:0]  rdrs_rd_data;
  logic           cgra_cfg_c2sw_rd_en;
  logic           cgra_cfg_c2sw_wr_en;
  logic [CAW-1:0] cgra_cfg_c2sw_addr;
  logic [CDW-1:0] cgra_cfg_c2sw_data;

  glb_tile_pcfg_dma #(
    .GLB_ADDR_WIDTH(AW), .BANK_DATA_WIDTH(DW), .CGRA_CFG_ADDR_WIDTH(CAW),
    .CGRA_CFG_DATA_WIDTH(CDW), .MAX_NUM_CFG_WIDTH(NW), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_pc_dma_mode(cfg_pc_dma_mode),
    .cfg_pc_dma_header_start_addr(cfg_pc_dma_header_start_addr),
    .cfg_pc_dma_header_num_cfg(cfg_pc_dma_header_num_cfg),
    .pc_start_pulse(pc_start_pulse), .pc_done_pulse(pc_done_pulse), .pc_busy(pc_busy),
    .rdrq_rd_en(rdrq_rd_en), .rdrq_rd_addr(rdrq_rd_addr),
    .rdrs_rd_data_valid(rdrs_rd_data_valid), .rdrs_rd_data(rdrs_rd_data),
    .cgra_cfg_c2sw_rd_en(cgra_cfg_c2sw_rd_en), .cgra_cfg_c2sw_wr_en(cgra_cfg_c2sw_wr_en),
    .cgra_cfg_c2sw_addr(cgra_cfg_c2sw_addr), .cgra_cfg_c2sw_data(cgra_cfg_c2sw_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [63:0] val;
  } exp_t;

  exp_t        rd_q[$];
  exp_t        wr_q[$];
  exp_t        done_q[$];
  int          busy_lo = 1;
  int          busy_hi = 0;
  logic [63:0] hold_exp = '0;
  int          total = 0;
  int          bad = 0;

  // Bank contents: a few fixed entries, everything else derived from the address.
  function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
    case (a)
      22'h000100: return 64'h00010000_AAAA0001;
      22'h000108: return 64'h00020000_BBBB0002;
      22'h000110: return 64'h00030000_CCCC0003;
      default:    return {32'hC000_0000 | 32'(a), 32'(a) * 32'h9E37_79B1};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic reportMiss(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Bank model: fixed-latency pipeline, plus an injectable stray response.
  logic        bank_vld [LAT] = '{default: 1'b0};
  logic [AW-1:0] bank_addr [LAT] = '{default: '0};
  logic        stray = 1'b0;
  logic [63:0] stray_data = '0;

  always @(posedge clk) begin
    bank_vld[0]  <= rdrq_rd_en;
    bank_addr[0] <= rdrq_rd_addr;
    for (int i = 1; i < LAT; i++) begin
      bank_vld[i]  <= bank_vld[i-1];
      bank_addr[i] <= bank_addr[i-1];
    end
  end

  assign rdrs_rd_data_valid = bank_vld[LAT-1] | stray;
  assign rdrs_rd_data       = bank_vld[LAT-1] ? mem_word(bank_addr[LAT-1]) : stray_data;

  // Monitor: pops expected events as the DUT presents them, one sample per cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (rdrq_rd_en) begin
        if (rd_q.size() == 0) reportMiss("rd_unexpected");
        else begin
          e = rd_q.pop_front();
          checkOutput("rd_cycle", 64'(cyc), 64'(e.cyc));
          checkOutput("rd_addr", 64'(rdrq_rd_addr), e.val);
        end
      end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        void'(rd_q.pop_front());
        reportMiss("rd_missing");
      end

      if (cgra_cfg_c2sw_wr_en) begin
        if (wr_q.size() == 0) reportMiss("wr_unexpected");
        else begin
          e = wr_q.pop_front();
          hold_exp = e.val;
          checkOutput("wr_cycle", 64'(cyc), 64'(e.cyc));
          checkOutput("wr_packet", {cgra_cfg_c2sw_addr, cgra_cfg_c2sw_data}, e.val);
        end
      end else begin
        if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
          void'(wr_q.pop_front());
          reportMiss("wr_missing");
        end
        checkOutput("wr_hold", {cgra_cfg_c2sw_addr, cgra_cfg_c2sw_data}, hold_exp);
      end

      if (pc_done_pulse) begin
        if (done_q.size() == 0) reportMiss("done_unexpected");
        else begin
          e = done_q.pop_front();
          checkOutput("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
        void'(done_q.pop_front());
        reportMiss("done_missing");
      end

      checkOutput("busy", 64'(pc_busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
      checkOutput("c2sw_rd_en", 64'(cgra_cfg_c2sw_rd_en), 64'(0));
    end
  end

  // Drives a one-cycle start; the reference model decides acceptance and
  // predicts every resulting read, packet and done from plain arithmetic.
  task automatic applyStimulus(input logic mode, input logic [AW-1:0] sa, input logic [NW-1:0] n);
    int t;
    logic [AW-1:0] base;
    logic [AW-1:0] a;
    @(negedge clk);
    t = cyc;
    cfg_pc_dma_mode              = mode;
    cfg_pc_dma_header_start_addr = sa;
    cfg_pc_dma_header_num_cfg    = n;
    pc_start_pulse               = 1'b1;
    if (mode && !(t >= busy_lo && t <= busy_hi)) begin
      base = sa & ~AW'(7);
      if (n == 0) begin
        done_q.push_back('{t + 1, 64'd0});
        busy_lo = t + 1;
        busy_hi = t + 1;
      end else begin
        for (int i = 0; i < int'(n); i++) begin
          a = base + AW'(8 * i);
          rd_q.push_back('{t + 1 + i, 64'(a)});
          wr_q.push_back('{t + 2 + LAT + i, mem_word(a)});
        end
        done_q.push_back('{t + 2 + LAT + int'(n), 64'd0});
        busy_lo = t + 1;
        busy_hi = t + 2 + LAT + int'(n);
      end
    end
    @(negedge clk);
    pc_start_pulse = 1'b0;
  endtask

  task automatic waitIdle();
    int guard = 0;
    while (cyc <= busy_hi + 2 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) reportMiss("idle_timeout");
    checkOutput("rd_q_left", 64'(rd_q.size()), 64'(0));
    checkOutput("wr_q_left", 64'(wr_q.size()), 64'(0));
    checkOutput("done_q_left", 64'(done_q.size()), 64'(0));
  endtask

  // Asserts reset between edges and checks that outputs clear at once.
  task automatic applyReset(input int hold);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_rd_en", 64'(rdrq_rd_en), 64'(0));
    checkOutput("rst_rd_addr", 64'(rdrq_rd_addr), 64'(0));
    checkOutput("rst_wr_en", 64'(cgra_cfg_c2sw_wr_en), 64'(0));
    checkOutput("rst_packet", {cgra_cfg_c2sw_addr, cgra_cfg_c2sw_data}, 64'(0));
    checkOutput("rst_done", 64'(pc_done_pulse), 64'(0));
    checkOutput("rst_busy", 64'(pc_busy), 64'(0));
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    hold_exp = '0;
    busy_lo  = 1;
    busy_hi  = 0;
    repeat (hold) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic strayPulse(input int len);
    @(negedge clk);
    stray      = 1'b1;
    stray_data = {$urandom, $urandom};
    repeat (len) @(negedge clk);
    stray = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        m;
    logic [NW-1:0] n;
    applyReset(3);
    repeat (2) @(negedge clk);

    applyStimulus(1'b1, 22'h000100, 16'd3);
    waitIdle();

    applyStimulus(1'b1, 22'h000200, 16'd0);
    waitIdle();

    applyStimulus(1'b0, 22'h000300, 16'd5);
    waitIdle();

    applyStimulus(1'b1, 22'h000400, 16'd4);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 22'h000500, 16'd4);
    waitIdle();

    applyStimulus(1'b1, 22'h3FFFF9, 16'd2);
    waitIdle();

    applyStimulus(1'b1, 22'h000600, 16'd4);
    repeat (4) @(negedge clk);
    applyReset(2);
    repeat (4) @(negedge clk);
    applyStimulus(1'b1, 22'h000700, 16'd4);
    waitIdle();

    strayPulse(1);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 22'h000800, 16'd3);
    repeat (4) @(negedge clk);
    stray      = 1'b1;
    stray_data = 64'hDEAD_BEEF_0BAD_F00D;
    repeat (2) @(negedge clk);
    stray = 1'b0;
    waitIdle();

    for (int k = 0; k < 30; k++) begin
      m = ($urandom_range(0, 7) != 0);
      n = ($urandom_range(0, 5) == 0) ? 16'd0 : NW'($urandom_range(1, 10));
      applyStimulus(m, AW'($urandom), n);
      if ($urandom_range(0, 1) == 1) cfg_pc_dma_mode = 1'b0;
      repeat ($urandom_range(0, 14)) @(negedge clk);
      if ($urandom_range(0, 2) == 0) applyStimulus(1'b1, AW'($urandom), NW'($urandom_range(0, 6)));
      waitIdle();
      if ($urandom_range(0, 3) == 0) strayPulse($urandom_range(1, 3));
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
